// File: rtl/y86_dmem_ctrl_if.sv
// Request/response bundle between the Y86 execute stage and the data-memory unit.
// The master drives requests. The slave (y86_dmem_ctrl) returns valM with a single-cycle pulse.
interface y86_dmem_ctrl_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic [3:0]            icode;
   logic [DATA_WIDTH-1:0] valA;
   logic [DATA_WIDTH-1:0] valE;
   logic [DATA_WIDTH-1:0] valP;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] valM;
   logic                  dmem_error;

   modport master (
      output req_valid, icode, valA, valE, valP,
      input  req_ready, resp_valid, valM, dmem_error
   );

   modport slave (
      input  req_valid, icode, valA, valE, valP,
      output req_ready, resp_valid, valM, dmem_error
   );
endinterface

// File: rtl/y86_dmem_ctrl.sv
// Y86 data-memory stage: decodes icode into a word read/write and applies LATENCY wait states.
// Each access ends with a one-cycle resp_valid pulse. Bad addresses report dmem_error.
module y86_dmem_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int DEPTH       = 128,
   parameter int ADDR_WIDTH  = 64,
   parameter int LATENCY     = 1,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input logic            clk,
   input logic            rst,
   y86_dmem_ctrl_if.slave bus
);
   localparam int WB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int CMP_W = (ADDR_WIDTH > 64) ? ADDR_WIDTH + 1 : 65;

   localparam logic [CMP_W-1:0]      MEM_BYTES = CMP_W'(DEPTH) * CMP_W'(WB);
   localparam logic [ADDR_WIDTH-1:0] WB_A      = ADDR_WIDTH'(WB);
   localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   op_t                   op_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   op_t                   dec_op;
   logic [DATA_WIDTH-1:0] dec_addr_val;
   logic [DATA_WIDTH-1:0] dec_wdata;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  range_err;
   logic                  align_err;
   logic                  dec_err;
   logic [IDX_W-1:0]      dec_idx;
   logic                  commit;

   // call pushes the return address (valP). ret and popq take their address from valA, not valE.
   always_comb begin
      dec_op       = OP_NONE;
      dec_addr_val = bus.valE;
      dec_wdata    = bus.valA;
      case (bus.icode)
         4'h4, 4'hA: dec_op = OP_WRITE;
         4'h8: begin
            dec_op    = OP_WRITE;
            dec_wdata = bus.valP;
         end
         4'h5: dec_op = OP_READ;
         4'h9, 4'hB: begin
            dec_op       = OP_READ;
            dec_addr_val = bus.valA;
         end
         default: dec_op = OP_NONE;
      endcase
   end

   assign addr      = ADDR_WIDTH'(dec_addr_val);
   assign range_err = CMP_W'(addr) >= MEM_BYTES;
   assign align_err = ALIGN_CHECK && ((addr % WB_A) != '0);
   assign dec_err   = (dec_op != OP_NONE) && (range_err || align_err);
   assign dec_idx   = IDX_W'(addr / WB_A);

   assign bus.req_ready = (state == IDLE) && !rst;

   // The write happens only on the access edge. If rst is high on that edge, the write is dropped.
   assign commit = !rst && (state == BUSY) && (cnt == '0) && (op_q == OP_WRITE) && !err_q;

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         op_q           <= OP_NONE;
         err_q          <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.valM       <= '0;
         bus.dmem_error <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q    <= dec_op;
                  idx_q   <= dec_idx;
                  wdata_q <= dec_wdata;
                  err_q   <= dec_err;
                  cnt     <= CNT_INIT;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  bus.resp_valid <= 1'b1;
                  bus.dmem_error <= err_q;
                  bus.valM       <= (op_q == OP_READ && !err_q) ? mem[idx_q] : '0;
                  state          <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
